// File: rtl/param_writeback.sv
// Parameter bank for the two-layer network: sweeps every weight/bias slot off the
// shared update bus on start, accepts host loads while idle, and exposes flat views.
module param_writeback #(
    parameter int N   = 32,
    parameter int SX  = 2,
    parameter int SL1 = 3,
    parameter int SL  = 2,
    localparam int WT = SX * SL1 + SL1 * SL,
    localparam int ND = SL1 + SL,
    localparam int S  = WT + ND,
    localparam int SW = $clog2(S)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ld_en,
    input  logic [SW-1:0]     ld_slot,
    input  logic [N-1:0]      ld_data,
    input  logic [2*N-1:0]    bus,
    output logic [S-1:0]      we,
    output logic              dtb,
    output logic              busy,
    output logic              done,
    output logic [N*WT-1:0]   wall,
    output logic [N*ND-1:0]   ball
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    localparam logic [SW-1:0] LAST = SW'(S - 1);
    localparam logic [S-1:0]  ONE  = S'(1);
    localparam int            L2   = SL1 * (SX + 1);

    state_t         state, state_nx;
    logic [SW-1:0]  s, s_nx;
    logic [S-1:0]   we_nx;
    logic           cap_en;
    logic [SW-1:0]  cap_slot;
    logic [N-1:0]   cap_data;
    logic [N-1:0]   par [S];

    always_comb begin
        state_nx = state;
        s_nx     = s;
        cap_en   = 1'b0;
        cap_slot = s;
        cap_data = bus[N-1:0];
        case (state)
            IDLE: begin
                // start takes priority; a simultaneous load is dropped
                if (start) begin
                    state_nx = SWEEP;
                    s_nx     = '0;
                end else if (ld_en && (ld_slot <= LAST)) begin
                    cap_en   = 1'b1;
                    cap_slot = ld_slot;
                    cap_data = ld_data;
                end
            end
            SWEEP: begin
                cap_en = 1'b1;
                if (s == LAST) begin
                    state_nx = DONE;
                    s_nx     = '0;
                end else begin
                    s_nx = s + 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // outputs are registered from the next state so they never glitch
        we_nx = (state_nx == SWEEP) ? (ONE << s_nx) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            we    <= '0;
            dtb   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < S; i++) begin
                par[i] <= '0;
            end
        end else begin
            state <= state_nx;
            s     <= s_nx;
            we    <= we_nx;
            dtb   <= (state_nx == SWEEP);
            busy  <= (state_nx == SWEEP);
            done  <= (state_nx == DONE);
            if (cap_en) begin
                par[cap_slot] <= cap_data;
            end
        end
    end

    // node-major slot layout: fan-in weights of a node, then its bias
    for (genvar k = 0; k < SL1; k++) begin : g_l1
        for (genvar j = 0; j < SX; j++) begin : g_w
            assign wall[(k*SX + j)*N +: N] = par[k*(SX+1) + j];
        end
        assign ball[k*N +: N] = par[k*(SX+1) + SX];
    end

    for (genvar k = 0; k < SL; k++) begin : g_l2
        for (genvar j = 0; j < SL1; j++) begin : g_w
            assign wall[(SX*SL1 + k*SL1 + j)*N +: N] = par[L2 + k*(SL1+1) + j];
        end
        assign ball[(SL1 + k)*N +: N] = par[L2 + k*(SL1+1) + SL1];
    end

endmodule
